// File: rtl/reconciled_key_frame_tracker_pkg.sv
// Shared encodings, field widths and saturating helpers for the reconciled-key frame tracker.
// The ER width constants mirror the ER parameter include and must stay in step with it.
package reconciled_key_frame_tracker_pkg;

  localparam int FRAME_LEAKED_INFO_WIDTH = 15;
  localparam int FRAME_ERROR_COUNT_WIDTH = 15;
  localparam int KEY_ADDR_WIDTH          = 15;
  localparam int DESC_WORD_CNT_WIDTH     = 16;
  localparam int DESC_FIFO_DEPTH         = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } tracker_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/reconciled_key_frame_tracker_fifo.sv
// Synchronous descriptor FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module frame_desc_fifo #(
  parameter int WIDTH = 61,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reconciled_key_frame_tracker.sv
// Snoops reconciled-key writes and ER frame results, builds one descriptor per verified frame
// for privacy amplification, and keeps saturating session statistics and sticky error flags.
module reconciled_key_frame_tracker
  import reconciled_key_frame_tracker_pkg::*;
#(
  parameter int LEAK_W     = FRAME_LEAKED_INFO_WIDTH,
  parameter int ERR_W      = FRAME_ERROR_COUNT_WIDTH,
  parameter int ADDR_W     = KEY_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DESC_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              session_start,
  input  logic              key_ena,
  input  logic [3:0]        key_wea,
  input  logic [ADDR_W-1:0] key_addra,
  input  logic              frame_param_valid,
  input  logic              frame_verify_fail,
  input  logic [LEAK_W-1:0] frame_leaked_info,
  input  logic [ERR_W-1:0]  frame_error_count,
  input  logic              er_finish,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [ADDR_W-1:0] desc_base_addr,
  output logic [15:0]       desc_word_cnt,
  output logic [LEAK_W-1:0] desc_leaked,
  output logic [ERR_W-1:0]  desc_err_cnt,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_fail,
  output logic [31:0]       total_key_words,
  output logic [31:0]       total_leaked,
  output logic              overflow_err,
  output logic              partial_write_err,
  output logic              orphan_err,
  output logic              session_done
);

  localparam int DESC_W = ADDR_W + 16 + LEAK_W + ERR_W;

  tracker_state_e    state_r;
  tracker_state_e    fsm_next_s;
  tracker_state_e    next_state_s;
  logic [ADDR_W-1:0] base_r;
  logic [15:0]       cnt_r;
  logic              active_s;
  logic              word_acc_s;
  logic              partial_s;
  logic              close_s;
  logic              finish_s;
  logic              collecting_s;
  logic [ADDR_W-1:0] close_base_s;
  logic [15:0]       close_cnt_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              push_s;
  logic              fail_drop_s;
  logic              overflow_s;
  logic              orphan_s;
  logic [DESC_W-1:0] push_data_s;
  logic [DESC_W-1:0] head_data_s;

  logic [15:0] frames_ok_r;
  logic [15:0] frames_fail_r;
  logic [31:0] total_key_words_r;
  logic [31:0] total_leaked_r;
  logic        overflow_err_r;
  logic        partial_write_err_r;
  logic        orphan_err_r;
  logic        session_done_r;

  // session_start masks every other input, and DONE ignores everything but session_start.
  assign active_s     = (state_r != ST_DONE) && !session_start;
  assign word_acc_s   = active_s && key_ena && (key_wea == 4'hF);
  assign partial_s    = active_s && key_ena && (key_wea != 4'h0) && (key_wea != 4'hF);
  assign close_s      = active_s && frame_param_valid;
  assign finish_s     = active_s && er_finish;
  assign collecting_s = (state_r == ST_COLLECT);

  // A word arriving with the close belongs to the frame being closed.
  assign close_base_s = collecting_s ? base_r : key_addra;
  assign close_cnt_s  = collecting_s ? (word_acc_s ? sat_inc16(cnt_r) : cnt_r)
                                     : {15'd0, word_acc_s};

  assign pop_s       = desc_ready && !fifo_empty_s;
  assign push_s      = close_s && !frame_verify_fail && (!fifo_full_s || pop_s);
  assign fail_drop_s = close_s && frame_verify_fail;
  assign overflow_s  = close_s && !frame_verify_fail && fifo_full_s && !pop_s;
  assign orphan_s    = finish_s && collecting_s && !close_s;
  assign push_data_s = {close_base_s, close_cnt_s, frame_leaked_info, frame_error_count};

  // Next-state decode; session_start beats er_finish, which beats the frame FSM.
  always_comb begin
    fsm_next_s   = state_r;
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:    fsm_next_s = (word_acc_s && !close_s) ? ST_COLLECT : ST_IDLE;
      ST_COLLECT: fsm_next_s = close_s ? ST_IDLE : ST_COLLECT;
      ST_DONE:    fsm_next_s = ST_DONE;
      default:    fsm_next_s = ST_IDLE;
    endcase
    if (session_start) begin
      next_state_s = ST_IDLE;
    end else if (finish_s) begin
      next_state_s = ST_DONE;
    end else begin
      next_state_s = fsm_next_s;
    end
  end

  // State register and open-frame capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      base_r  <= {ADDR_W{1'b0}};
      cnt_r   <= 16'd0;
    end else begin
      state_r <= next_state_s;
      if (session_start) begin
        base_r <= {ADDR_W{1'b0}};
        cnt_r  <= 16'd0;
      end else if (word_acc_s && !close_s && (state_r == ST_IDLE)) begin
        base_r <= key_addra;
        cnt_r  <= 16'd1;
      end else if (word_acc_s && !close_s && collecting_s) begin
        cnt_r <= sat_inc16(cnt_r);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Session statistics, sticky flags and the done indicator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_ok_r         <= 16'd0;
      frames_fail_r       <= 16'd0;
      total_key_words_r   <= 32'd0;
      total_leaked_r      <= 32'd0;
      overflow_err_r      <= 1'b0;
      partial_write_err_r <= 1'b0;
      orphan_err_r        <= 1'b0;
      session_done_r      <= 1'b0;
    end else if (session_start) begin
      frames_ok_r         <= 16'd0;
      frames_fail_r       <= 16'd0;
      total_key_words_r   <= 32'd0;
      total_leaked_r      <= 32'd0;
      overflow_err_r      <= 1'b0;
      partial_write_err_r <= 1'b0;
      orphan_err_r        <= 1'b0;
      session_done_r      <= 1'b0;
    end else begin
      if (push_s) begin
        frames_ok_r       <= sat_inc16(frames_ok_r);
        total_key_words_r <= sat_add32(total_key_words_r, {16'd0, close_cnt_s});
        total_leaked_r    <= sat_add32(total_leaked_r, {{(32-LEAK_W){1'b0}}, frame_leaked_info});
      end
      if (fail_drop_s) begin
        frames_fail_r <= sat_inc16(frames_fail_r);
      end
      if (overflow_s) begin
        overflow_err_r <= 1'b1;
      end
      if (partial_s) begin
        partial_write_err_r <= 1'b1;
      end
      if (orphan_s) begin
        orphan_err_r <= 1'b1;
      end
      session_done_r <= (next_state_s == ST_DONE);
    end
  end

  frame_desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (desc_ready),
    .pop_data  (head_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign desc_valid = !fifo_empty_s;
  assign {desc_base_addr, desc_word_cnt, desc_leaked, desc_err_cnt} = head_data_s;

  assign frames_ok         = frames_ok_r;
  assign frames_fail       = frames_fail_r;
  assign total_key_words   = total_key_words_r;
  assign total_leaked      = total_leaked_r;
  assign overflow_err      = overflow_err_r;
  assign partial_write_err = partial_write_err_r;
  assign orphan_err        = orphan_err_r;
  assign session_done      = session_done_r;

endmodule

// File: tb/tb_reconciled_key_frame_tracker.sv
// Scoreboard bench for reconciled_key_frame_tracker: expected descriptors are queued when a
// frame is closed and compared when the consumer handshake retires them.
module tb_reconciled_key_frame_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        session_start = 1'b0;
  logic        key_ena = 1'b0;
  logic [3:0]  key_wea = 4'h0;
  logic [14:0] key_addra = 15'd0;
  logic        frame_param_valid = 1'b0;
  logic        frame_verify_fail = 1'b0;
  logic [14:0] frame_leaked_info = 15'd0;
  logic [14:0] frame_error_count = 15'd0;
  logic        er_finish = 1'b0;
  logic        desc_valid;
  logic        desc_ready = 1'b0;
  logic [14:0] desc_base_addr;
  logic [15:0] desc_word_cnt;
  logic [14:0] desc_leaked;
  logic [14:0] desc_err_cnt;
  logic [15:0] frames_ok;
  logic [15:0] frames_fail;
  logic [31:0] total_key_words;
  logic [31:0] total_leaked;
  logic        overflow_err;
  logic        partial_write_err;
  logic        orphan_err;
  logic        session_done;

  typedef struct packed {
    logic [14:0] base;
    logic [15:0] cnt;
    logic [14:0] leak;
    logic [14:0] err;
  } desc_t;

  desc_t exp_q[$];
  desc_t mon_exp;
  desc_t mon_got;
  int    n_checks = 0;
  int    n_fail = 0;

  reconciled_key_frame_tracker dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .session_start     (session_start),
    .key_ena           (key_ena),
    .key_wea           (key_wea),
    .key_addra         (key_addra),
    .frame_param_valid (frame_param_valid),
    .frame_verify_fail (frame_verify_fail),
    .frame_leaked_info (frame_leaked_info),
    .frame_error_count (frame_error_count),
    .er_finish         (er_finish),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_base_addr    (desc_base_addr),
    .desc_word_cnt     (desc_word_cnt),
    .desc_leaked       (desc_leaked),
    .desc_err_cnt      (desc_err_cnt),
    .frames_ok         (frames_ok),
    .frames_fail       (frames_fail),
    .total_key_words   (total_key_words),
    .total_leaked      (total_leaked),
    .overflow_err      (overflow_err),
    .partial_write_err (partial_write_err),
    .orphan_err        (orphan_err),
    .session_done      (session_done)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every handshake retires the oldest expected descriptor.
  always @(negedge clk) begin
    #2;
    if (desc_valid && desc_ready) begin
      n_checks++;
      mon_got = {desc_base_addr, desc_word_cnt, desc_leaked, desc_err_cnt};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL desc_unexpected: got base=%0d cnt=%0d leak=%0d err=%0d, expected none",
                 desc_base_addr, desc_word_cnt, desc_leaked, desc_err_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL desc_fields: got base=%0d cnt=%0d leak=%0d err=%0d, expected base=%0d cnt=%0d leak=%0d err=%0d",
                   mon_got.base, mon_got.cnt, mon_got.leak, mon_got.err,
                   mon_exp.base, mon_exp.cnt, mon_exp.leak, mon_exp.err);
        end
      end
    end
  end

  task automatic write_word(input logic [14:0] addr, input logic [3:0] wea);
    key_ena = 1'b1; key_wea = wea; key_addra = addr;
    @(negedge clk);
    key_ena = 1'b0; key_wea = 4'h0;
  endtask

  task automatic close_frame(input logic fail, input logic [14:0] leak,
                             input logic [14:0] err, input logic [14:0] addr);
    frame_param_valid = 1'b1; frame_verify_fail = fail;
    frame_leaked_info = leak; frame_error_count = err; key_addra = addr;
    @(negedge clk);
    frame_param_valid = 1'b0; frame_verify_fail = 1'b0;
  endtask

  task automatic pulse_session_start();
    session_start = 1'b1;
    @(negedge clk);
    session_start = 1'b0;
  endtask

  task automatic drain();
    desc_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    desc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({desc_valid, overflow_err, partial_write_err, orphan_err, session_done} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {desc_valid, overflow_err, partial_write_err, orphan_err, session_done});
    end
    n_checks++;
    if ({frames_ok, frames_fail, total_key_words, total_leaked} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got ok=%0d fail=%0d words=%0d leak=%0d expected all 0",
               frames_ok, frames_fail, total_key_words, total_leaked);
    end
    n_checks++;
    if ({desc_base_addr, desc_word_cnt, desc_leaked, desc_err_cnt} !== 61'd0) begin
      n_fail++;
      $display("FAIL reset_desc: got base=%0d cnt=%0d expected 0", desc_base_addr, desc_word_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    pulse_session_start();
    for (int i = 0; i < 256; i++) write_word(15'(100 + i), 4'hF);
    exp_q.push_back('{base: 15'd100, cnt: 16'd256, leak: 15'd300, err: 15'd12});
    close_frame(1'b0, 15'd300, 15'd12, 15'd0);
    n_checks++;
    if (desc_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_desc_valid: got %b expected 1", desc_valid);
    end
    n_checks++;
    if (frames_ok !== 16'd1) begin
      n_fail++; $display("FAIL basic_frames_ok: got %0d expected 1", frames_ok);
    end
    n_checks++;
    if (total_key_words !== 32'd256 || total_leaked !== 32'd300) begin
      n_fail++;
      $display("FAIL basic_totals: got words=%0d leak=%0d expected 256/300", total_key_words, total_leaked);
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0 || desc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got pending=%0d valid=%b expected 0/0", exp_q.size(), desc_valid);
    end
  endtask

  task automatic test_verify_fail();
    pulse_session_start();
    for (int i = 0; i < 256; i++) write_word(15'(100 + i), 4'hF);
    close_frame(1'b1, 15'd300, 15'd12, 15'd0);
    @(negedge clk);
    n_checks++;
    if (desc_valid !== 1'b0) begin
      n_fail++; $display("FAIL vfail_desc_valid: got %b expected 0", desc_valid);
    end
    n_checks++;
    if (frames_fail !== 16'd1 || frames_ok !== 16'd0) begin
      n_fail++; $display("FAIL vfail_counts: got fail=%0d ok=%0d expected 1/0", frames_fail, frames_ok);
    end
    n_checks++;
    if (total_key_words !== 32'd0 || total_leaked !== 32'd0) begin
      n_fail++;
      $display("FAIL vfail_totals: got words=%0d leak=%0d expected 0/0", total_key_words, total_leaked);
    end
  endtask

  task automatic test_overflow();
    pulse_session_start();
    desc_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      write_word(15'(1000 + 10 * k), 4'hF);
      write_word(15'(1001 + 10 * k), 4'hF);
      write_word(15'(1002 + 10 * k), 4'hF);
      if (k < 4) exp_q.push_back('{base: 15'(1000 + 10 * k), cnt: 16'd3, leak: 15'(k + 1), err: 15'(k + 2)});
      close_frame(1'b0, 15'(k + 1), 15'(k + 2), 15'd0);
    end
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow_err);
    end
    n_checks++;
    if (frames_ok !== 16'd4 || total_key_words !== 32'd12 || total_leaked !== 32'd10) begin
      n_fail++;
      $display("FAIL ovf_stats: got ok=%0d words=%0d leak=%0d expected 4/12/10",
               frames_ok, total_key_words, total_leaked);
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL ovf_drain: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    pulse_session_start();
    for (int k = 0; k < 4; k++) begin
      write_word(15'(2000 + k), 4'hF);
      exp_q.push_back('{base: 15'(2000 + k), cnt: 16'd1, leak: 15'd9, err: 15'd1});
      close_frame(1'b0, 15'd9, 15'd1, 15'd0);
    end
    desc_ready = 1'b1;
    exp_q.push_back('{base: 15'd333, cnt: 16'd0, leak: 15'd4, err: 15'd5});
    close_frame(1'b0, 15'd4, 15'd5, 15'd333);
    n_checks++;
    if (overflow_err !== 1'b0 || frames_ok !== 16'd5) begin
      n_fail++;
      $display("FAIL b2b_full_push_pop: got ovf=%b ok=%0d expected 0/5", overflow_err, frames_ok);
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0 || desc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got pending=%0d valid=%b expected 0/0", exp_q.size(), desc_valid);
    end
  endtask

  task automatic test_wrap_partial();
    pulse_session_start();
    write_word(15'd32766, 4'hF);
    write_word(15'd32767, 4'hF);
    write_word(15'd0, 4'hF);
    write_word(15'd1, 4'hF);
    write_word(15'd2, 4'h3);
    n_checks++;
    if (partial_write_err !== 1'b1) begin
      n_fail++; $display("FAIL wrap_partial_flag: got %b expected 1", partial_write_err);
    end
    exp_q.push_back('{base: 15'd32766, cnt: 16'd4, leak: 15'd5, err: 15'd1});
    close_frame(1'b0, 15'd5, 15'd1, 15'd0);
    exp_q.push_back('{base: 15'd77, cnt: 16'd0, leak: 15'd2, err: 15'd0});
    close_frame(1'b0, 15'd2, 15'd0, 15'd77);
    n_checks++;
    if (total_key_words !== 32'd4 || frames_ok !== 16'd2) begin
      n_fail++;
      $display("FAIL wrap_totals: got words=%0d ok=%0d expected 4/2", total_key_words, frames_ok);
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_drain: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_orphan_session();
    pulse_session_start();
    for (int i = 0; i < 10; i++) write_word(15'(500 + i), 4'hF);
    er_finish = 1'b1;
    @(negedge clk);
    er_finish = 1'b0;
    n_checks++;
    if (orphan_err !== 1'b1 || session_done !== 1'b1 || desc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_flags: got orphan=%b done=%b valid=%b expected 1/1/0",
               orphan_err, session_done, desc_valid);
    end
    write_word(15'd600, 4'hF);
    close_frame(1'b0, 15'd1, 15'd1, 15'd0);
    n_checks++;
    if (desc_valid !== 1'b0 || frames_ok !== 16'd0 || frames_fail !== 16'd0) begin
      n_fail++;
      $display("FAIL done_ignores: got valid=%b ok=%0d fail=%0d expected 0/0/0",
               desc_valid, frames_ok, frames_fail);
    end
    pulse_session_start();
    n_checks++;
    if ({orphan_err, session_done, overflow_err, partial_write_err} !== 4'd0 ||
        {frames_ok, frames_fail, total_key_words, total_leaked} !== 96'd0) begin
      n_fail++;
      $display("FAIL session_clear: got orphan=%b done=%b ok=%0d words=%0d expected all 0",
               orphan_err, session_done, frames_ok, total_key_words);
    end
    write_word(15'd50, 4'hF);
    write_word(15'd51, 4'hF);
    exp_q.push_back('{base: 15'd50, cnt: 16'd2, leak: 15'd3, err: 15'd4});
    close_frame(1'b0, 15'd3, 15'd4, 15'd0);
    n_checks++;
    if (frames_ok !== 16'd1) begin
      n_fail++; $display("FAIL restart_idle: got ok=%0d expected 1", frames_ok);
    end
    drain();
  endtask

  task automatic test_coincident_finish();
    pulse_session_start();
    for (int i = 0; i < 5; i++) write_word(15'(200 + i), 4'hF);
    key_ena = 1'b1; key_wea = 4'hF; key_addra = 15'd205;
    frame_param_valid = 1'b1; frame_verify_fail = 1'b0;
    frame_leaked_info = 15'd7; frame_error_count = 15'd3; er_finish = 1'b1;
    exp_q.push_back('{base: 15'd200, cnt: 16'd6, leak: 15'd7, err: 15'd3});
    @(negedge clk);
    key_ena = 1'b0; key_wea = 4'h0; frame_param_valid = 1'b0; er_finish = 1'b0;
    n_checks++;
    if (orphan_err !== 1'b0 || session_done !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_flags: got orphan=%b done=%b expected 0/1", orphan_err, session_done);
    end
    n_checks++;
    if (frames_ok !== 16'd1 || total_key_words !== 32'd6 || desc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_enqueue: got ok=%0d words=%0d valid=%b expected 1/6/1",
               frames_ok, total_key_words, desc_valid);
    end
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL coinc_drain: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_verify_fail();
    test_overflow();
    test_back_to_back();
    test_wrap_partial();
    test_orphan_session();
    test_coincident_finish();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
